// File: rtl/fwft_bram_fifo_if.sv
// rtl/fwft_bram_fifo_if.sv - push/pop handshake bundle for the FWFT write-queue FIFO
interface fwft_bram_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int AW = $clog2(DEPTH);

    logic             push_i;
    logic [WIDTH-1:0] data_i;
    logic             full_o;
    logic             pop_i;
    logic [WIDTH-1:0] data_o;
    logic             empty_o;
    logic [AW:0]      usage_o;

    modport master (
        output push_i, data_i, pop_i,
        input  full_o, data_o, empty_o, usage_o
    );

    modport slave (
        input  push_i, data_i, pop_i,
        output full_o, data_o, empty_o, usage_o
    );
endinterface

// File: rtl/fwft_bram_fifo.sv
// rtl/fwft_bram_fifo.sv - single-clock first-word-fall-through FIFO over a dual-port array
module fwft_bram_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fwft_bram_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = bus.push_i && !w_full;
    assign w_pop_ok  = bus.pop_i && !w_empty;

    assign bus.full_o  = w_full;
    assign bus.empty_o = w_empty;
    assign bus.usage_o = r_count;
    // Asynchronous read gives the head entry without a read-latency cycle.
    assign bus.data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
    end

    // DEPTH is a power of two, so AW-bit pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_fwft_bram_fifo.sv
// tb/tb_fwft_bram_fifo.sv - scoreboard bench for fwft_bram_fifo with DEPTH=4, WIDTH=8
module tb_fwft_bram_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb_q[$];
    int               model_cnt = 0;

    fwft_bram_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fwft_bram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop that will be accepted at the next edge must see the scoreboard head.
    always @(negedge clk_i) begin
        if (rst_i && bus.pop_i === 1'b1 && sb_q.size() > 0) begin
            chk("pop_data", 32'(bus.data_o), 32'(sb_q.pop_front()));
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_usage"}, 32'(bus.usage_o), 32'(model_cnt));
        chk({tag, "_full"},  32'(bus.full_o),  32'(model_cnt == DEPTH));
        chk({tag, "_empty"}, 32'(bus.empty_o), 32'(model_cnt == 0));
    endtask

    task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic q);
        logic push_ok;
        logic pop_ok;
        push_ok     = p && (model_cnt < DEPTH);
        pop_ok      = q && (model_cnt > 0);
        bus.push_i  = p;
        bus.data_i  = d;
        bus.pop_i   = q;
        @(posedge clk_i);
        #1;
        if (push_ok) sb_q.push_back(d);
        if (push_ok && !pop_ok) model_cnt++;
        if (pop_ok && !push_ok) model_cnt--;
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
        bus.data_i = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

    initial begin
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
        bus.data_i = '0;

        // Reset then idle
        repeat (2) @(posedge clk_i);
        #1;
        check_state("in_reset");
        rst_i = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_state("idle");

        // Fill and overflow
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        check_state("filled");
        chk("filled_head", 32'(bus.data_o), 32'h11);
        step(1'b1, 8'h55, 1'b0);
        check_state("overflow");
        chk("overflow_usage4", 32'(bus.usage_o), 32'd4);

        // Drain and underflow
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        check_state("drained");
        chk("drained_empty", 32'(bus.empty_o), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check_state("underflow");

        // Simultaneous push/pop on empty, mid, and full
        step(1'b1, 8'hA5, 1'b1);
        check_state("pp_empty");
        chk("pp_empty_head", 32'(bus.data_o), 32'hA5);
        step(1'b1, 8'hB6, 1'b0);
        step(1'b1, 8'hC7, 1'b1);
        check_state("pp_mid");
        chk("pp_mid_head", 32'(bus.data_o), 32'hB6);
        step(1'b1, 8'hD8, 1'b0);
        step(1'b1, 8'hE9, 1'b0);
        check_state("pre_pp_full");
        step(1'b1, 8'hF0, 1'b1);
        check_state("pp_full");
        chk("pp_full_usage3", 32'(bus.usage_o), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        check_state("pp_drained");

        // Wrap-around stress
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            check_state("rand");
        end
        while (model_cnt > 0) step(1'b0, 8'h00, 1'b1);
        check_state("rand_drained");

        // Asynchronous reset mid-stream
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h62, 1'b0);
        step(1'b1, 8'h63, 1'b0);
        check_state("pre_async");
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_empty", 32'(bus.empty_o), 32'd1);
        chk("async_usage", 32'(bus.usage_o), 32'd0);
        sb_q.delete();
        model_cnt = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        step(1'b1, 8'h7E, 1'b0);
        check_state("post_reset_push");
        chk("post_reset_head", 32'(bus.data_o), 32'h7E);
        step(1'b0, 8'h00, 1'b1);
        check_state("post_reset_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwft_bram_fifo.md
Name: fwft_bram_fifo

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO with an internal dual-port memory array for storage.
- Queues write transactions (address, data and byte-select streams) between a cache front end and a slave bus.
- The head entry is always visible on data_o without a read-latency cycle.
- Occupancy is reported so the producer can throttle before the FIFO fills.

Parameters:
- WIDTH, 8: bit width of each entry.
- DEPTH, 2: number of entries. Must be a power of two and at least 2.
- Derived: AW = clog2(DEPTH), the pointer width.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_i  input  1  reset; asynchronous, active-low (asserted when 0).
- push_i  input  1  write request; data_i is enqueued on the clock edge if not full.
- data_i  input  WIDTH  entry to enqueue.
- full_o  output  1  high when usage_o == DEPTH.
- pop_i  input  1  read request; the head entry is dequeued on the clock edge if not empty.
- data_o  output  WIDTH  current head entry (FWFT), combinational from storage.
- empty_o  output  1  high when usage_o == 0.
- usage_o  output  AW+1  number of stored entries, range 0..DEPTH.

Behaviour:
- Storage:
  - DEPTH x WIDTH array with a write port at wr_ptr and an asynchronous read at rd_ptr.
  - The array is not reset; its contents after power-up are don't-care.
- Pointers:
  - wr_ptr and rd_ptr are AW-bit registers that wrap from DEPTH-1 to 0.
  - A separate AW+1-bit count register drives usage_o.
- Reset (rst_i = 0, takes effect immediately, independent of clk_i):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Therefore empty_o = 1, full_o = 0, usage_o = 0.
  - Reset asserted mid-operation discards all queued entries.
- Accept conditions, evaluated from pre-edge state:
  - push_ok = push_i && !full_o
  - pop_ok = pop_i && !empty_o
- On each rising edge, out of reset:
  - push_ok: mem[wr_ptr] <= data_i; wr_ptr advances.
  - pop_ok: rd_ptr advances.
  - count: +1 when only push_ok, -1 when only pop_ok, unchanged when both or neither.
- Boundary conditions:
  - Push when full: ignored; data is dropped, no state change. This holds even if pop_i is high in the same cycle — the pop is performed and the push is dropped.
  - Pop when empty: ignored. Push+pop on an empty FIFO: push accepted, pop ignored, count becomes 1.
  - Push+pop when neither empty nor full: both performed, count unchanged, order preserved.
- FWFT timing:
  - Data pushed into an empty FIFO appears on data_o in the cycle after the push edge.
  - empty_o deasserts in that same cycle.
  - After a pop edge, data_o shows the next entry in the following cycle with no extra latency.
- data_o while empty: shows mem[rd_ptr] (stale); value unspecified and not checked.
- Outputs full_o, empty_o and usage_o are decoded combinationally from count; no glitch requirements.
- Ordering: strict FIFO; entries exit in push order across pointer wrap-around.

Test Plan:
- Reset then idle: hold rst_i = 0 for 2 cycles, release, no push/pop -> usage_o = 0, empty_o = 1, full_o = 0.
- Fill and overflow, DEPTH = 4, WIDTH = 8:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> usage_o = 4, full_o = 1, data_o = 0x11.
  - Further push 0x55 -> ignored, usage_o stays 4.
- Drain and underflow:
  - From the full state, pop 4 times -> data_o sequence 0x11, 0x22, 0x33, 0x44 presented before each pop edge; then empty_o = 1.
  - Extra pop -> usage_o stays 0.
- Simultaneous push/pop:
  - On empty, push 0xA5 + pop -> usage_o = 1, data_o = 0xA5 next cycle.
  - With 2 entries, push + pop -> usage_o = 2, head advances.
  - When full, push + pop -> usage_o = 3, pushed value not stored.
- Wrap-around stress: 20 interleaved random push/pop cycles with DEPTH = 4 -> output stream matches a scoreboard queue exactly; usage_o always equals the model count.
- Asynchronous reset mid-stream: with 3 entries queued, drive rst_i low between clock edges -> empty_o = 1 and usage_o = 0 immediately, before the next edge; after release the FIFO accepts a new push 0x7E and presents it next cycle.
